// File: rtl/month_year_counter.sv
// Calendar month and BCD year counter for the millennium clock.
// Ports: clk, rst_n, inc, dec, ctrl_set, sel_year, carry_in_day in;
//        current_month[3:0], year_bcd[15:0], is_leap_year, carry_out out.
module month_year_counter #(
    parameter logic [3:0]  RESET_MONTH = 4'd1,
    parameter logic [15:0] RESET_YEAR  = 16'h2000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    input  logic        dec,
    input  logic        ctrl_set,
    input  logic        sel_year,
    input  logic        carry_in_day,
    output logic [3:0]  current_month,
    output logic [15:0] year_bcd,
    output logic        is_leap_year,
    output logic        carry_out
);

    logic [3:0]  month_q, month_d;
    logic [15:0] year_q, year_d;
    logic        month_ok;

    // BCD +1 with ripple; 9999 wraps to 0000.
    function automatic logic [15:0] bcd_inc(input logic [15:0] y);
        logic [15:0] r;
        logic        c;
        r = y;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // BCD -1 with borrow ripple; 0000 wraps to 9999.
    function automatic logic [15:0] bcd_dec(input logic [15:0] y);
        logic [15:0] r;
        logic        b;
        r = y;
        b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (b) begin
                if (r[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Two BCD digits t:u divisible by 4.
    function automatic logic div4(input logic [3:0] t, input logic [3:0] u);
        logic u048, u26;
        u048 = (u == 4'd0) || (u == 4'd4) || (u == 4'd8);
        u26  = (u == 4'd2) || (u == 4'd6);
        return t[0] ? u26 : u048;
    endfunction

    assign month_ok = (month_q != 4'd0) && (month_q <= 4'd12);

    always_comb begin
        month_d = month_q;
        year_d  = year_q;
        if (!ctrl_set) begin
            if (carry_in_day) begin
                if (!month_ok) begin
                    month_d = 4'd1;
                end else if (month_q == 4'd12) begin
                    month_d = 4'd1;
                    year_d  = bcd_inc(year_q);
                end else begin
                    month_d = month_q + 4'd1;
                end
            end
        end else if (inc || dec) begin
            if (sel_year) begin
                year_d = inc ? bcd_inc(year_q) : bcd_dec(year_q);
                if (!month_ok) month_d = 4'd1;
            end else if (!month_ok) begin
                month_d = 4'd1;
            end else if (inc) begin
                month_d = (month_q == 4'd12) ? 4'd1 : month_q + 4'd1;
            end else begin
                month_d = (month_q == 4'd1) ? 4'd12 : month_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            month_q <= RESET_MONTH;
            year_q  <= RESET_YEAR;
        end else begin
            month_q <= month_d;
            year_q  <= year_d;
        end
    end

    assign current_month = month_q;
    assign year_bcd      = year_q;

    // A century year falls back to the thousands:hundreds pair.
    assign is_leap_year = (year_q[7:0] != 8'h00)
                        ? div4(year_q[7:4], year_q[3:0])
                        : div4(year_q[15:12], year_q[11:8]);

    assign carry_out = carry_in_day && !ctrl_set
                    && (month_q == 4'd12) && (year_q == 16'h9999);

endmodule

// File: tb/tb_month_year_counter.sv
// Bench for month_year_counter: integer calendar model plus
// directed literal checks.
module tb_month_year_counter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        inc = 1'b0;
    logic        dec = 1'b0;
    logic        ctrl_set = 1'b0;
    logic        sel_year = 1'b0;
    logic        carry_in_day = 1'b0;
    logic [3:0]  current_month;
    logic [15:0] year_bcd;
    logic        is_leap_year;
    logic        carry_out;

    int n_total = 0;
    int n_pass  = 0;
    int m_month = 1;
    int m_year  = 2000;
    bit cmp_en  = 1'b0;

    month_year_counter dut (
        .clk(clk),
        .rst_n(rst_n),
        .inc(inc),
        .dec(dec),
        .ctrl_set(ctrl_set),
        .sel_year(sel_year),
        .carry_in_day(carry_in_day),
        .current_month(current_month),
        .year_bcd(year_bcd),
        .is_leap_year(is_leap_year),
        .carry_out(carry_out)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int y);
        return {4'(y / 1000), 4'((y / 100) % 10),
                4'((y / 10) % 10), 4'(y % 10)};
    endfunction

    function automatic bit leap(input int y);
        return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Calendar model in plain integers.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_month = 1;
            m_year  = 2000;
        end else if (!ctrl_set) begin
            if (carry_in_day) begin
                if (m_month == 12) begin
                    m_month = 1;
                    m_year  = (m_year + 1) % 10000;
                end else begin
                    m_month = m_month + 1;
                end
            end
        end else if (inc) begin
            if (sel_year) m_year = (m_year + 1) % 10000;
            else m_month = m_month % 12 + 1;
        end else if (dec) begin
            if (sel_year) m_year = (m_year + 9999) % 10000;
            else m_month = (m_month == 1) ? 12 : m_month - 1;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_month", 32'(current_month), 32'(m_month));
            check("model_year", 32'(year_bcd), 32'(to_bcd(m_year)));
            check("model_leap", 32'(is_leap_year), 32'(leap(m_year)));
            check("model_carry", 32'(carry_out),
                  32'(carry_in_day && !ctrl_set && m_month == 12
                      && m_year == 9999));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_step(input bit y, input bit up, input int n);
        ctrl_set = 1'b1;
        sel_year = y;
        for (int i = 0; i < n; i++) begin
            inc = up;
            dec = !up;
            tick();
        end
        inc = 1'b0;
        dec = 1'b0;
    endtask

    initial begin
        #1 cmp_en = 1'b1;
        inc = 1'b1;
        repeat (3) tick();
        check("reset_month", 32'(current_month), 32'd1);
        check("reset_year", 32'(year_bcd), 32'h2000);
        check("reset_leap", 32'(is_leap_year), 32'd1);
        check("reset_carry", 32'(carry_out), 32'd0);
        inc = 1'b0;
        rst_n = 1'b1;
        tick();

        // month 1 -> 12 by set-mode dec, year untouched
        set_step(1'b0, 1'b0, 1);
        check("mon_dec_wrap", 32'(current_month), 32'd12);
        check("mon_dec_year", 32'(year_bcd), 32'h2000);
        set_step(1'b1, 1'b1, 99);
        check("year_2099", 32'(year_bcd), 32'h2099);

        ctrl_set = 1'b0;
        carry_in_day = 1'b1;
        #1 check("roll_carry0", 32'(carry_out), 32'd0);
        tick();
        carry_in_day = 1'b0;
        check("roll_month", 32'(current_month), 32'd1);
        check("roll_year", 32'(year_bcd), 32'h2100);
        check("roll_leap", 32'(is_leap_year), 32'd0);

        // leap sweep 1896 .. 2404
        set_step(1'b1, 1'b0, 204);
        check("sw_1896", 32'({year_bcd, 3'b0, is_leap_year}), 32'h18961);
        set_step(1'b1, 1'b1, 4);
        check("sw_1900", 32'({year_bcd, 3'b0, is_leap_year}), 32'h19000);
        set_step(1'b1, 1'b1, 100);
        check("sw_2000", 32'({year_bcd, 3'b0, is_leap_year}), 32'h20001);
        set_step(1'b1, 1'b1, 24);
        check("sw_2024", 32'({year_bcd, 3'b0, is_leap_year}), 32'h20241);
        set_step(1'b1, 1'b1, 376);
        check("sw_2400", 32'({year_bcd, 3'b0, is_leap_year}), 32'h24001);
        set_step(1'b1, 1'b1, 4);

        // down to 0000, then wrap to 9999
        set_step(1'b1, 1'b0, 2404);
        check("year_0000", 32'(year_bcd), 32'h0000);
        set_step(1'b1, 1'b0, 1);
        check("year_dec_wrap", 32'(year_bcd), 32'h9999);
        check("year_dec_carry", 32'(carry_out), 32'd0);

        set_step(1'b0, 1'b0, 1);
        check("mil_month12", 32'(current_month), 32'd12);
        ctrl_set = 1'b0;
        carry_in_day = 1'b1;
        #1 check("mil_carry", 32'(carry_out), 32'd1);
        tick();
        carry_in_day = 1'b0;
        check("mil_month", 32'(current_month), 32'd1);
        check("mil_year", 32'(year_bcd), 32'h0000);
        check("mil_leap", 32'(is_leap_year), 32'd1);

        // inc has priority over dec
        set_step(1'b0, 1'b1, 4);
        check("mon_5", 32'(current_month), 32'd5);
        inc = 1'b1;
        dec = 1'b1;
        tick();
        inc = 1'b0;
        dec = 1'b0;
        check("both_inc", 32'(current_month), 32'd6);

        // mode isolation
        ctrl_set = 1'b1;
        carry_in_day = 1'b1;
        #1 check("set_no_carry", 32'(carry_out), 32'd0);
        repeat (3) tick();
        carry_in_day = 1'b0;
        check("iso_set_month", 32'(current_month), 32'd6);
        check("iso_set_year", 32'(year_bcd), 32'h0000);
        ctrl_set = 1'b0;
        inc = 1'b1;
        sel_year = 1'b1;
        repeat (3) tick();
        inc = 1'b0;
        check("iso_norm_year", 32'(year_bcd), 32'h0000);
        check("iso_norm_month", 32'(current_month), 32'd6);

        // mid-sequence async reset
        set_step(1'b0, 1'b1, 1);
        set_step(1'b1, 1'b1, 2345);
        check("pre_rst", 32'({current_month, year_bcd}), 32'h72345);
        #1 rst_n = 1'b0;
        #1 check("async_rst", 32'({current_month, year_bcd}), 32'h12000);
        tick();
        rst_n = 1'b1;
        ctrl_set = 1'b0;
        tick();

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
